// File: rtl/wb_stage.sv
// wb_stage: stage-3 writeback unit and register-file write-port driver.
//
// Registers the stage-2 result and picks the writeback source: ALU result,
// aligned load data, or PC+4. The same rd/wb_data/we triple feeds the
// register-file write port and the stage-1 forwarding path. A two-state
// load-hold FSM snapshots the data-memory word on the first stall edge, so
// a load keeps returning the same data however long the stall lasts.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   stall               hold all stage-3 state
//   flush               kill the instruction being captured from stage 2
//   s2_valid, s2_regwen, s2_rd, s2_wb_sel, s2_funct3, s2_alu_out, s2_pc
//                       stage-2 instruction fields
//   dmem_rdata          data-memory read word for the load in stage 3
//   rd, wb_data, we     register-file write port and forwarding source
//   s3_valid            stage 3 holds a live instruction
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        s2_valid,
    input  logic        s2_regwen,
    input  logic [4:0]  s2_rd,
    input  logic [1:0]  s2_wb_sel,
    input  logic [2:0]  s2_funct3,
    input  logic [31:0] s2_alu_out,
    input  logic [31:0] s2_pc,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  rd,
    output logic [31:0] wb_data,
    output logic        we,
    output logic        s3_valid
);
    typedef struct packed {
        logic        valid;
        logic        regwen;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic [2:0]  funct3;
        logic [31:0] alu_out;
        logic [31:0] pc;
    } stage_t;

    typedef enum logic {IDLE, HOLD} hold_state_t;

    stage_t      s3;
    hold_state_t hold_state, hold_state_nxt;
    logic        hold_valid;
    logic        hold_cap;
    logic [31:0] hold_data;

    // Stage register: stall wins over flush; flush only kills valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3 <= '0;
        end else if (!stall) begin
            s3.valid   <= s2_valid & ~flush;
            s3.regwen  <= s2_regwen;
            s3.rd      <= s2_rd;
            s3.wb_sel  <= s2_wb_sel;
            s3.funct3  <= s2_funct3;
            s3.alu_out <= s2_alu_out;
            s3.pc      <= s2_pc;
        end
    end

    // Load-hold FSM state and captured word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_state <= IDLE;
            hold_data  <= '0;
        end else begin
            hold_state <= hold_state_nxt;
            if (hold_cap) hold_data <= dmem_rdata;
        end
    end

    always_comb begin
        hold_state_nxt = hold_state;
        hold_cap       = 1'b0;
        case (hold_state)
            IDLE: if (stall) begin
                hold_state_nxt = HOLD;
                hold_cap       = 1'b1;
            end
            HOLD: if (!stall) hold_state_nxt = IDLE;
            default: hold_state_nxt = IDLE;
        endcase
    end

    assign hold_valid = (hold_state == HOLD);

    // Load alignment, little-endian. Halfwords use offset[1] only.
    logic [31:0] ld_word;
    logic [31:0] ld_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_word  = hold_valid ? hold_data : dmem_rdata;
        ld_shift = ld_word >> {s3.alu_out[1:0], 3'b000};
        ld_byte  = ld_shift[7:0];
        ld_half  = s3.alu_out[1] ? ld_word[31:16] : ld_word[15:0];
        case (s3.funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        case (s3.wb_sel)
            2'b00:   wb_data = s3.alu_out;
            2'b01:   wb_data = ld_data;
            2'b10:   wb_data = s3.pc + 32'd4;
            default: wb_data = '0;
        endcase
    end

    // Not gated by stall: the register file qualifies the write itself.
    assign we       = s3.valid & s3.regwen & (s3.wb_sel != 2'b11) & (s3.rd != 5'd0);
    assign rd       = s3.rd;
    assign s3_valid = s3.valid;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage. A small register
// file model commits writes the way the real one would (we & ~stall).
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        s2_valid, s2_regwen;
    logic [4:0]  s2_rd;
    logic [1:0]  s2_wb_sel;
    logic [2:0]  s2_funct3;
    logic [31:0] s2_alu_out, s2_pc, dmem_rdata;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        we, s3_valid;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] rf [32];

    wb_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .s2_valid(s2_valid), .s2_regwen(s2_regwen), .s2_rd(s2_rd),
        .s2_wb_sel(s2_wb_sel), .s2_funct3(s2_funct3),
        .s2_alu_out(s2_alu_out), .s2_pc(s2_pc), .dmem_rdata(dmem_rdata),
        .rd(rd), .wb_data(wb_data), .we(we), .s3_valid(s3_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (we && !stall) rf[rd] <= wb_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic s2(input logic v, input logic wen, input logic [4:0] r,
                      input logic [1:0] sel, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] pc);
        s2_valid = v; s2_regwen = wen; s2_rd = r; s2_wb_sel = sel;
        s2_funct3 = f3; s2_alu_out = alu; s2_pc = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; dmem_rdata = '0;
        s2(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
        #2;
        chk("reset_we", {31'b0, we}, 32'd0);
        chk("reset_rd", {27'b0, rd}, 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_s3_valid", {31'b0, s3_valid}, 32'd0);
        reset = 1'b0;

        // ALU writeback and register-file commit one edge later
        s2(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h1234_5678, 32'h0);
        tick();
        chk("alu_we", {31'b0, we}, 32'd1);
        chk("alu_rd", {27'b0, rd}, 32'd5);
        chk("alu_wb_data", wb_data, 32'h1234_5678);
        s2(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
        tick();
        chk("alu_rf_x5", rf[5], 32'h1234_5678);
        chk("bubble_s3_valid", {31'b0, s3_valid}, 32'd0);

        // Load alignment
        dmem_rdata = 32'h80FF_7F01;
        s2(1'b1, 1'b1, 5'd6, 2'b01, 3'b000, 32'h0000_0103, 32'h0); tick();
        chk("lb_off3", wb_data, 32'hFFFF_FF80);
        s2(1'b1, 1'b1, 5'd6, 2'b01, 3'b100, 32'h0000_0103, 32'h0); tick();
        chk("lbu_off3", wb_data, 32'h0000_0080);
        s2(1'b1, 1'b1, 5'd6, 2'b01, 3'b000, 32'h0000_0101, 32'h0); tick();
        chk("lb_off1", wb_data, 32'h0000_007F);
        s2(1'b1, 1'b1, 5'd6, 2'b01, 3'b001, 32'h0000_0102, 32'h0); tick();
        chk("lh_off2", wb_data, 32'hFFFF_80FF);
        s2(1'b1, 1'b1, 5'd6, 2'b01, 3'b001, 32'h0000_0103, 32'h0); tick();
        chk("lh_off3", wb_data, 32'hFFFF_80FF);
        s2(1'b1, 1'b1, 5'd6, 2'b01, 3'b101, 32'h0000_0100, 32'h0); tick();
        chk("lhu_off0", wb_data, 32'h0000_7F01);
        s2(1'b1, 1'b1, 5'd6, 2'b01, 3'b010, 32'h0000_0101, 32'h0); tick();
        chk("lw_off1", wb_data, 32'h80FF_7F01);
        s2(1'b1, 1'b1, 5'd6, 2'b01, 3'b011, 32'h0000_0102, 32'h0); tick();
        chk("f3_011_word", wb_data, 32'h80FF_7F01);

        // JAL link and wrap
        s2(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0, 32'h0000_1000); tick();
        chk("jal_link", wb_data, 32'h0000_1004);
        chk("jal_we", {31'b0, we}, 32'd1);
        s2(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0, 32'hFFFF_FFFC); tick();
        chk("jal_wrap", wb_data, 32'h0000_0000);

        // x0 and kill cases
        s2(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h0000_0042, 32'h0); tick();
        chk("x0_we", {31'b0, we}, 32'd0);
        chk("x0_s3_valid", {31'b0, s3_valid}, 32'd1);
        flush = 1'b1;
        s2(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'h0000_0042, 32'h0); tick();
        flush = 1'b0;
        chk("flush_we", {31'b0, we}, 32'd0);
        chk("flush_s3_valid", {31'b0, s3_valid}, 32'd0);
        s2(1'b1, 1'b1, 5'd7, 2'b11, 3'b000, 32'h0000_0042, 32'h0); tick();
        chk("sel11_we", {31'b0, we}, 32'd0);
        chk("sel11_wb_data", wb_data, 32'd0);

        // stall + flush together: stall wins
        s2(1'b1, 1'b1, 5'd8, 2'b00, 3'b000, 32'h0000_0088, 32'h0); tick();
        stall = 1'b1; flush = 1'b1;
        s2(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'h0000_0099, 32'h0); tick();
        chk("stflush_s3_valid", {31'b0, s3_valid}, 32'd1);
        chk("stflush_rd", {27'b0, rd}, 32'd8);
        chk("stflush_wb_data", wb_data, 32'h0000_0088);
        stall = 1'b0; flush = 1'b0;
        s2(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0); tick();

        // Stall with load: first stall cycle live, later cycles held word
        s2(1'b1, 1'b1, 5'd7, 2'b01, 3'b010, 32'h0000_0200, 32'h0); tick();
        stall = 1'b1; dmem_rdata = 32'hAAAA_AAAA;
        s2(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0);
        #1;
        chk("stall_c1_wb_data", wb_data, 32'hAAAA_AAAA);
        tick();
        dmem_rdata = 32'h5555_5555;
        #1;
        chk("stall_c2_wb_data", wb_data, 32'hAAAA_AAAA);
        chk("stall_c2_rd", {27'b0, rd}, 32'd7);
        tick();
        chk("stall_c3_wb_data", wb_data, 32'hAAAA_AAAA);
        chk("stall_c3_hold_valid", {31'b0, dut.hold_valid}, 32'd1);
        stall = 1'b0;
        tick();
        chk("unstall_hold_valid", {31'b0, dut.hold_valid}, 32'd0);
        chk("unstall_rd", {27'b0, rd}, 32'd9);
        chk("unstall_wb_data", wb_data, 32'hDEAD_BEEF);

        // Async reset mid-stall
        s2(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h0000_0011, 32'h0); tick();
        stall = 1'b1; tick();
        chk("pre_reset_we", {31'b0, we}, 32'd1);
        chk("pre_reset_hold", {31'b0, dut.hold_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_we", {31'b0, we}, 32'd0);
        chk("areset_rd", {27'b0, rd}, 32'd0);
        chk("areset_wb_data", wb_data, 32'd0);
        chk("areset_s3_valid", {31'b0, s3_valid}, 32'd0);
        chk("areset_hold", {31'b0, dut.hold_valid}, 32'd0);
        reset = 1'b0; stall = 1'b0;
        dmem_rdata = 32'h0BAD_F00D;
        s2(1'b1, 1'b1, 5'd4, 2'b01, 3'b010, 32'h0000_0300, 32'h0); tick();
        chk("post_reset_lw", wb_data, 32'h0BAD_F00D);
        chk("post_reset_we", {31'b0, we}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Stage-3 writeback unit: the write-side driver of the register file. It registers the stage-2 result and selects the writeback source: ALU result, aligned load data, or PC+4. It then presents `rd`, `wb_data` and `we` to the register file's write port. The same three signals also serve as the stage-1 forwarding source. It holds state under `stall` and keeps load data stable across multi-cycle stalls.

## Interface
- None. The datapath is fixed at 32 bits and the register index at 5 bits.

- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `stall`  in  1  1 = hold all stage-3 state (same signal the register file sees)
- `flush`  in  1  1 = the instruction being captured from stage 2 is killed
- `s2_valid`  in  1  stage-2 instruction is valid
- `s2_regwen`  in  1  instruction writes a register
- `s2_rd`  in  5  destination register index
- `s2_wb_sel`  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (no write)
- `s2_funct3`  in  3  load width/sign code
- `s2_alu_out`  in  32  ALU result, or load byte address
- `s2_pc`  in  32  instruction PC
- `dmem_rdata`  in  32  data-memory read word; valid in the cycle the load occupies stage 3
- `rd`  out  5  register-file write index
- `wb_data`  out  32  register-file write data
- `we`  out  1  register-file write enable
- `s3_valid`  out  1  stage 3 holds a live instruction

## Operation
- Stage register contents: `valid`, `regwen`, `rd`, `wb_sel`, `funct3`, `alu_out`, `pc`.
- Rising edge with `stall`=0:
  - Capture all stage-2 fields.
  - `valid` <= `s2_valid` & ~`flush`.
- Rising edge with `stall`=1:
  - All stage fields are unchanged.
  - `flush` is ignored; the controller holds `flush` until the first non-stall edge.
- `we` = `valid` & `regwen` & (`wb_sel` != 11) & (`rd` != 0). This is combinational from stage state only and is not gated by `stall`; the register file gates writes itself.
- `rd` output = stage `rd`.
- `wb_data` select:
  - `wb_sel` 00: `alu_out`.
  - `wb_sel` 10: `pc` + 4, mod 2^32; 0xFFFFFFFC wraps to 0x00000000.
  - `wb_sel` 01: aligned load (rules below).
  - `wb_sel` 11: 0.
- Load source word: `hold_data` if `hold_valid`=1, else `dmem_rdata`.
- Load alignment: little-endian, offset = `alu_out[1:0]`.
  - funct3 000 LB: byte at offset, sign-extended.
  - funct3 100 LBU: byte at offset, zero-extended.
  - funct3 001 LH: halfword at offset[1], sign-extended; offset[0] ignored.
  - funct3 101 LHU: halfword at offset[1], zero-extended; offset[0] ignored.
  - funct3 010 LW, 011, 110, 111: full word, offset ignored.
- Load-hold FSM, two states:
  - IDLE (`hold_valid`=0) -> HOLD on an edge with `stall`=1; `hold_data` <= `dmem_rdata` on that edge.
  - HOLD (`hold_valid`=1) -> IDLE on an edge with `stall`=0; `hold_data` is unchanged while in HOLD.
  - The first stall cycle uses live `dmem_rdata`; later stall cycles use the captured word. This holds whatever the `wb_sel` value.

## Timing
- Reset values, all reached asynchronously:
  - `valid`=0, `regwen`=0, `rd`=0, `wb_sel`=00, `funct3`=000, `alu_out`=0, `pc`=0.
  - `hold_valid`=0, `hold_data`=0.
  - Outputs: `rd`=0, `wb_data`=0, `we`=0, `s3_valid`=0.
- Latency:
  - Stage-2 fields captured at edge N appear on the outputs after edge N.
  - The register file commits the write at edge N+1, provided `stall`=0 at N+1.
- Writes to x0 never assert `we`.
- Reset asserted mid-stall or mid-load:
  - All state clears immediately.
  - After deassertion, the first captured instruction behaves as if out of reset.
- `stall` and `flush` high together: `stall` has priority, so state holds.

## Test plan
- ALU writeback:
  - Stimulus: `s2_valid`=1, `regwen`=1, `rd`=5, `wb_sel`=00, `alu_out`=0x1234_5678, `stall`=0.
  - Response: next cycle `we`=1, `rd`=5, `wb_data`=0x1234_5678; x5 reads 0x1234_5678 one edge later.
- Load alignment:
  - Stimulus: `dmem_rdata`=0x80FF_7F01.
  - LB off 3 -> 0xFFFF_FF80; LBU off 3 -> 0x0000_0080; LH off 2 -> 0xFFFF_80FF.
  - LHU off 0 -> 0x0000_7F01; LW off 1 -> 0x80FF_7F01.
- JAL link and wrap:
  - `wb_sel`=10, `pc`=0x0000_1000 -> `wb_data`=0x0000_1004.
  - `pc`=0xFFFF_FFFC -> `wb_data`=0x0000_0000.
- x0 and kill cases, each -> `we`=0:
  - `rd`=0 with `regwen`=1.
  - `flush`=1 at capture (also `s3_valid`=0).
  - `wb_sel`=11.
- Stall with load:
  - Stimulus: LW in stage 3, `stall`=1 for 3 cycles; `dmem_rdata`=0xAAAA_AAAA in the first cycle, then changes to 0x5555_5555.
  - Response: `wb_data` stays 0xAAAA_AAAA for all 3 cycles, and stage fields are unchanged.
  - On `stall`=0, `hold_valid` clears and the next instruction is captured.
- Async reset:
  - Stimulus: assert `reset` between edges while `we`=1 and `hold_valid`=1.
  - Response: `we`, `rd`, `wb_data`, `s3_valid` go to 0 before the next edge.
